// File: rtl/regfile_mp_pkg.sv
// Shared register-file constants and the write-qualification helper used by the
// register file and its busy scoreboard.
package regfile_mp_pkg;

   localparam int              REG_BUS     = 32;
   localparam int              REG_NUM     = 32;
   localparam int              REG0        = 0;
   localparam logic [REG_BUS-1:0] REG_RST_VAL = '0;
   localparam logic [REG_BUS-1:0] REG0_VAL    = '0;
   localparam logic            RST_VAL     = 1'b0;

   // A write is real unless it targets the hardwired zero register.
   function automatic logic wr_ok(input logic en, input logic addr_is0, input logic zero_reg);
      return en & ~(zero_reg & addr_is0);
   endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bundle of the register file's read, write and issue ports.
interface regfile_mp_if
   import regfile_mp_pkg::*;
#(
   parameter int XLEN = REG_BUS,
   parameter int NREG = REG_NUM,
   parameter int NRD  = 2,
   parameter int NWR  = 1
);
   localparam int AW = $clog2(NREG);

   logic [NWR-1:0]      wr_en;
   logic [NWR*AW-1:0]   wr_addr;
   logic [NWR*XLEN-1:0] wr_data;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                iss_en;
   logic [AW-1:0]       iss_addr;
   logic [NREG-1:0]     busy_vec;

   modport master (
      output wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr,
      input  rd_data, rd_busy, busy_vec
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr,
      output rd_data, rd_busy, busy_vec
   );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback, issue wins a tie.
module regfile_scoreboard
   import regfile_mp_pkg::*;
#(
   parameter int NREG     = REG_NUM,
   parameter int AW       = $clog2(NREG),
   parameter int NWR      = 1,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              iss_en,
   input  logic [AW-1:0]     iss_addr,
   input  logic [NWR-1:0]    clr_en,
   input  logic [NWR*AW-1:0] clr_addr,
   output logic [NREG-1:0]   busy_vec
);

   logic [NREG-1:0] busy_next;

   always_comb begin
      busy_next = busy_vec;
      for (int k = 0; k < NWR; k++) begin
         if (clr_en[k]) busy_next[clr_addr[k*AW +: AW]] = 1'b0;
      end
      // Applied after the clears so a fresh producer stays outstanding.
      if (iss_en) busy_next[iss_addr] = 1'b1;
      if (ZERO_REG != 0) busy_next[REG0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) busy_vec <= {NREG{RST_VAL}};
      else     busy_vec <= busy_next;
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and a
// RAW-hazard busy scoreboard.
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int XLEN     = REG_BUS,
   parameter int NREG     = REG_NUM,
   parameter int AW       = $clog2(NREG),
   parameter int NRD      = 2,
   parameter int NWR      = 1,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input logic         clk,
   input logic         rst,
   regfile_mp_if.slave bus
);

   logic [XLEN-1:0] regs    [NREG];
   logic [AW-1:0]   wr_idx  [NWR];
   logic [XLEN-1:0] wr_word [NWR];
   logic [NWR-1:0]  wr_live;
   logic [AW-1:0]   rd_idx  [NRD];
   logic [XLEN-1:0] rd_val  [NRD];
   logic [NWR*AW-1:0] clr_addr;

   for (genvar k = 0; k < NWR; k++) begin : g_wr
      assign wr_idx[k]  = bus.wr_addr[k*AW +: AW];
      assign wr_word[k] = bus.wr_data[k*XLEN +: XLEN];
      assign wr_live[k] = wr_ok(bus.wr_en[k], wr_idx[k] == '0, ZERO_REG != 0);
   end

   assign clr_addr = bus.wr_addr;

   // Ascending port order lets the highest-numbered port win a same-index conflict.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= XLEN'(REG_RST_VAL);
      end else begin
         for (int k = 0; k < NWR; k++) begin
            if (wr_live[k]) regs[wr_idx[k]] <= wr_word[k];
         end
      end
   end

   always_comb begin
      for (int j = 0; j < NRD; j++) begin
         rd_idx[j] = bus.rd_addr[j*AW +: AW];
         rd_val[j] = regs[rd_idx[j]];
         if (BYPASS != 0) begin
            for (int k = 0; k < NWR; k++) begin
               if (wr_live[k] && wr_idx[k] == rd_idx[j]) rd_val[j] = wr_word[k];
            end
         end
         if (ZERO_REG != 0 && rd_idx[j] == '0) rd_val[j] = XLEN'(REG0_VAL);
      end
   end

   // rd_busy shows the registered state; same-cycle wakeup is left to issue logic.
   always_comb begin
      bus.rd_data = '0;
      bus.rd_busy = '0;
      for (int j = 0; j < NRD; j++) begin
         bus.rd_data[j*XLEN +: XLEN] = rd_val[j];
         bus.rd_busy[j]              = bus.busy_vec[rd_idx[j]];
      end
   end

   regfile_scoreboard #(
      .NREG     (NREG),
      .AW       (AW),
      .NWR      (NWR),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .iss_en   (bus.iss_en),
      .iss_addr (bus.iss_addr),
      .clr_en   (wr_live),
      .clr_addr (clr_addr),
      .busy_vec (bus.busy_vec)
   );

endmodule
